// File: rtl/ccff_chain_loader.sv
// rtl/ccff_chain_loader.sv - CCFF chain bitstream loader; define CCFF_LOADER_VERIFY_EN for the parity verify pass
module ccff_chain_loader #(
   parameter int CHAIN_LEN = 64,
   parameter int WORD_W    = 8,
   parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
   input  logic              CLK,
   input  logic              RESET_B,
   input  logic              start,
   input  logic              abort,
   input  logic [WORD_W-1:0] bs_data,
   input  logic              bs_valid,
   output logic              bs_ready,
   output logic              ccff_head,
   output logic              ccff_shift_en,
   input  logic              ccff_tail,
   output logic              cfge,
   output logic              busy,
   output logic              done,
   output logic              err
);

   // buf_cnt must hold WORD_W; comparisons against bit_cnt use a common width
   localparam int BC_W = $clog2(WORD_W + 1);
   localparam int CW   = (CNT_W > BC_W) ? CNT_W : BC_W;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_SHIFT  = 3'd1;
   localparam logic [2:0] S_ARM    = 3'd3;
   localparam logic [2:0] S_DONE   = 3'd4;
`ifdef CCFF_LOADER_VERIFY_EN
   localparam logic [2:0] S_VERIFY = 3'd2;
`endif

   logic [2:0]        state;
   logic [WORD_W-1:0] word_buf;
   logic [BC_W-1:0]   buf_cnt;
   logic [CNT_W-1:0]  bit_cnt;
   logic              cfge_q;
`ifdef CCFF_LOADER_VERIFY_EN
   logic              err_q;
   logic              par_in;
   logic              par_out;
   logic              in_verify;
   logic              verify_last;
`endif

   logic [CW-1:0] bit_cnt_x;
   logic [CW-1:0] buf_cnt_x;
   logic          in_shift;
   logic          shift_fire;
   logic          accept;
   logic          last_shift;

   assign bit_cnt_x  = CW'(bit_cnt);
   assign buf_cnt_x  = CW'(buf_cnt);
   assign in_shift   = (state == S_SHIFT);
   assign shift_fire = in_shift && (buf_cnt != '0);
   // Refill only when the buffer is about to run dry and more chain bits are still owed
   assign bs_ready   = in_shift && (buf_cnt_x <= CW'(1)) && (bit_cnt_x > buf_cnt_x);
   assign accept     = bs_valid && bs_ready;
   assign last_shift = shift_fire && (bit_cnt == CNT_W'(1));

   assign cfge = cfge_q;
   assign done = (state == S_DONE);

`ifdef CCFF_LOADER_VERIFY_EN
   assign in_verify     = (state == S_VERIFY);
   assign verify_last   = in_verify && (bit_cnt == CNT_W'(1));
   assign ccff_shift_en = shift_fire || in_verify;
   // Recirculate tail into head so the verify pass leaves the chain unchanged
   assign ccff_head     = in_verify ? ccff_tail : (in_shift & word_buf[0]);
   assign busy          = in_shift || in_verify || (state == S_ARM);
   assign err           = err_q;
`else
   assign ccff_shift_en = shift_fire;
   assign ccff_head     = in_shift & word_buf[0];
   assign busy          = in_shift || (state == S_ARM);
   assign err           = 1'b0;
`endif

   // Controller state, word buffer, bit counters and registered CFGE
   always_ff @(posedge CLK or negedge RESET_B) begin
      if (!RESET_B) begin
         state    <= S_IDLE;
         word_buf <= '0;
         buf_cnt  <= '0;
         bit_cnt  <= '0;
         cfge_q   <= 1'b0;
`ifdef CCFF_LOADER_VERIFY_EN
         err_q    <= 1'b0;
         par_in   <= 1'b0;
         par_out  <= 1'b0;
`endif
      end else if (abort) begin
         state    <= S_IDLE;
         word_buf <= '0;
         buf_cnt  <= '0;
         bit_cnt  <= '0;
         cfge_q   <= 1'b0;
`ifdef CCFF_LOADER_VERIFY_EN
         err_q    <= 1'b0;
         par_in   <= 1'b0;
         par_out  <= 1'b0;
`endif
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  state    <= S_SHIFT;
                  bit_cnt  <= CNT_W'(CHAIN_LEN);
                  buf_cnt  <= '0;
                  word_buf <= '0;
                  cfge_q   <= 1'b0;
`ifdef CCFF_LOADER_VERIFY_EN
                  err_q    <= 1'b0;
                  par_in   <= 1'b0;
                  par_out  <= 1'b0;
`endif
               end
            end
            S_SHIFT: begin
               if (shift_fire) begin
                  word_buf <= word_buf >> 1;
                  buf_cnt  <= buf_cnt - BC_W'(1);
                  bit_cnt  <= bit_cnt - CNT_W'(1);
`ifdef CCFF_LOADER_VERIFY_EN
                  par_in   <= par_in ^ word_buf[0];
`endif
               end
               // A new word overrides the shift update of the buffer on the same edge
               if (accept) begin
                  word_buf <= bs_data;
                  buf_cnt  <= BC_W'(WORD_W);
               end
               // Leftover bits of the final word are dropped here
               if (last_shift) begin
                  word_buf <= '0;
                  buf_cnt  <= '0;
`ifdef CCFF_LOADER_VERIFY_EN
                  state    <= S_VERIFY;
                  bit_cnt  <= CNT_W'(CHAIN_LEN);
                  par_out  <= 1'b0;
`else
                  state    <= S_ARM;
`endif
               end
            end
`ifdef CCFF_LOADER_VERIFY_EN
            S_VERIFY: begin
               par_out <= par_out ^ ccff_tail;
               bit_cnt <= bit_cnt - CNT_W'(1);
               if (verify_last) begin
                  if (par_in != (par_out ^ ccff_tail)) begin
                     err_q <= 1'b1;
                     state <= S_IDLE;
                  end else begin
                     state <= S_ARM;
                  end
               end
            end
`endif
            S_ARM: begin
               state  <= S_DONE;
               cfge_q <= 1'b1;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// tb/tb_ccff_chain_loader.sv - randomized bench for ccff_chain_loader against a bit-queue reference model
module tb_ccff_chain_loader;

   localparam int L = 20;
   localparam int W = 8;

   logic         CLK = 1'b0;
   logic         RESET_B = 1'b0;
   logic         start = 1'b0;
   logic         abort = 1'b0;
   logic [W-1:0] bs_data = '0;
   logic         bs_valid = 1'b0;
   logic         bs_ready;
   logic         ccff_head;
   logic         ccff_shift_en;
   logic         ccff_tail;
   logic         cfge;
   logic         busy;
   logic         done;
   logic         err;
   logic         flip_now = 1'b0;
   logic [L-1:0] chain = '0;

   int total = 0;
   int bad = 0;

   always #5 CLK = ~CLK;

   ccff_chain_loader #(.CHAIN_LEN(L), .WORD_W(W)) dut (
      .CLK(CLK), .RESET_B(RESET_B), .start(start), .abort(abort),
      .bs_data(bs_data), .bs_valid(bs_valid), .bs_ready(bs_ready),
      .ccff_head(ccff_head), .ccff_shift_en(ccff_shift_en), .ccff_tail(ccff_tail),
      .cfge(cfge), .busy(busy), .done(done), .err(err)
   );

   // Fabric chain: first shifted bit ends up at chain[0] (the tail cell)
   always @(posedge CLK) if (ccff_shift_en) chain <= {ccff_head, chain[L-1:1]};
   assign ccff_tail = chain[0] ^ flip_now;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic run_load(input int valid_pct, input int abort_at, input bit do_flip);
      bit           q[$];
      bit           stream[$];
      int           rem;
      int           shifts;
      int           guard;
      bit           exp_rdy;
      bit           sh;
      bit           hs;
      logic [W-1:0] dword;
      logic [L-1:0] exp_chain;
      start = 1'b1;
      @(posedge CLK); @(negedge CLK);
      start = 1'b0;
      rem = L; shifts = 0; guard = 0;
      while (rem > 0) begin
         if (shifts == abort_at) begin
            abort = 1'b1; start = 1'b0; bs_valid = 1'b0;
            @(posedge CLK); @(negedge CLK);
            abort = 1'b0;
            check("abort_busy", busy, 1'b0);
            check("abort_cfge", cfge, 1'b0);
            check("abort_ready", bs_ready, 1'b0);
            check("abort_shift_en", ccff_shift_en, 1'b0);
            check("abort_done", done, 1'b0);
            return;
         end
         bs_valid = ($urandom_range(99) < valid_pct);
         bs_data  = W'($urandom);
         start    = ($urandom_range(15) == 0);
         #1;
         exp_rdy = (q.size() <= 1) && (rem > q.size());
         check("shift_busy", busy, 1'b1);
         check("shift_cfge", cfge, 1'b0);
         check("bs_ready", bs_ready, exp_rdy);
         check("shift_en", ccff_shift_en, q.size() != 0);
         if (q.size() != 0) check("head", ccff_head, q[0]);
         sh = (q.size() != 0);
         hs = bs_valid && exp_rdy;
         dword = bs_data;
         @(posedge CLK);
         if (sh) begin
            stream.push_back(q.pop_front());
            rem--;
            shifts++;
         end
         if (hs) for (int i = 0; i < W; i++) q.push_back(dword[i]);
         if (rem == 0) q.delete();
         @(negedge CLK);
         guard++;
         if (guard > 4000) begin
            check("load_timeout", 32'd0, 32'd1);
            rem = 0;
         end
      end
      bs_valid = 1'b0;
      start = 1'b0;
`ifdef CCFF_LOADER_VERIFY_EN
      for (int c = 0; c < L; c++) begin
         flip_now = do_flip && (c == 0);
         #1;
         check("verify_shift_en", ccff_shift_en, 1'b1);
         check("verify_head", ccff_head, ccff_tail);
         check("verify_busy", busy, 1'b1);
         @(posedge CLK); @(negedge CLK);
      end
      flip_now = 1'b0;
      if (do_flip) begin
         check("flip_err", err, 1'b1);
         check("flip_cfge", cfge, 1'b0);
         check("flip_busy", busy, 1'b0);
         check("flip_done", done, 1'b0);
         return;
      end
`else
      if (do_flip) check("flip_unsupported", 32'd0, 32'd1);
`endif
      check("arm_busy", busy, 1'b1);
      check("arm_shift_en", ccff_shift_en, 1'b0);
      check("arm_cfge", cfge, 1'b0);
      check("arm_done", done, 1'b0);
      @(posedge CLK); @(negedge CLK);
      check("done", done, 1'b1);
      check("done_cfge", cfge, 1'b1);
      check("done_busy", busy, 1'b0);
      check("done_err", err, 1'b0);
      bs_valid = 1'b1;
      #1;
      check("done_ready", bs_ready, 1'b0);
      check("done_shift_en", ccff_shift_en, 1'b0);
      bs_valid = 1'b0;
      for (int i = 0; i < L; i++) exp_chain[i] = (i < stream.size()) ? stream[i] : 1'b0;
      check("shift_count", stream.size(), L);
      check("chain", chain, exp_chain);
      @(posedge CLK); @(negedge CLK);
      check("done_hold", done, 1'b1);
      check("done_hold_cfge", cfge, 1'b1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      repeat (2) @(negedge CLK);
      check("rst_ready", bs_ready, 1'b0);
      check("rst_head", ccff_head, 1'b0);
      check("rst_shift_en", ccff_shift_en, 1'b0);
      check("rst_cfge", cfge, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_err", err, 1'b0);
      RESET_B = 1'b1;
      @(negedge CLK);
      run_load(100, -1, 1'b0);
      run_load(40, -1, 1'b0);
      run_load(100, 5, 1'b0);
      run_load(100, -1, 1'b0);
      run_load(70, 0, 1'b0);
`ifdef CCFF_LOADER_VERIFY_EN
      run_load(100, -1, 1'b1);
      run_load(60, -1, 1'b0);
`endif
      for (int n = 0; n < 6; n++) run_load(int'($urandom_range(90, 20)), -1, 1'b0);
      @(negedge CLK);
      RESET_B = 1'b0;
      #1;
      check("async_rst_cfge", cfge, 1'b0);
      check("async_rst_done", done, 1'b0);
      check("async_rst_busy", busy, 1'b0);
      @(negedge CLK);
      RESET_B = 1'b1;
      @(negedge CLK);
      check("post_rst_done", done, 1'b0);
      run_load(100, -1, 1'b0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
